// File: rtl/gpio_port.sv
// gpio_port: bus-mapped GPIO with direction/output latches, synchronised inputs and edge interrupts.
// Optional per-pin debounce filter enabled by defining GPIO_DEBOUNCE_EN.
module gpio_port #(
    parameter int          NUM_PINS        = 8,
    parameter logic [23:0] BASE_ADDR       = 24'h2060,
    parameter int          DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                bus_write,
    input  logic                bus_read,
    input  logic [23:0]         bus_address_in,
    input  logic [7:0]          bus_data_in,
    output logic [7:0]          bus_data_out,
    input  logic [NUM_PINS-1:0] pins_in,
    output logic [NUM_PINS-1:0] pins_out,
    output logic [NUM_PINS-1:0] pins_oe,
    output logic                irq
);

`ifdef GPIO_DEBOUNCE_EN
    localparam int PRIME_CLKS = DEBOUNCE_CYCLES + 3;
`else
    localparam int PRIME_CLKS = 3;
`endif
    // Priming counter is sized for the longest (debounced) latency in every build.
    localparam int                PCW        = $clog2(DEBOUNCE_CYCLES + 4);
    localparam logic [PCW-1:0]    PRIME_LAST = PCW'(PRIME_CLKS - 1);

    logic [NUM_PINS-1:0] dir, data_lat, ien, edge_sel, pend, pend_next;
    logic [NUM_PINS-1:0] sync1, sync2, filt, prev;
    logic [NUM_PINS-1:0] wr_val, clr, evt, data_view;
    logic [PCW-1:0]      prime_cnt;
    logic                primed;
    logic                hit_dir, hit_data, hit_ien, hit_edge, hit_pend;

    assign hit_dir  = (bus_address_in == BASE_ADDR);
    assign hit_data = (bus_address_in == BASE_ADDR + 24'd1);
    assign hit_ien  = (bus_address_in == BASE_ADDR + 24'd2);
    assign hit_edge = (bus_address_in == BASE_ADDR + 24'd3);
    assign hit_pend = (bus_address_in == BASE_ADDR + 24'd4);

    assign wr_val   = bus_data_in[NUM_PINS-1:0];
    assign pins_out = data_lat;
    assign pins_oe  = dir;
    assign irq      = |(pend & ien);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= pins_in;
            sync2 <= sync1;
            prev  <= filt;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);
    logic [3:0] db_cnt [NUM_PINS];

    // filt follows sync2 only after it has differed from filt for DEBOUNCE_CYCLES clocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt <= '0;
            for (int unsigned i = 0; i < NUM_PINS; i++) db_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_PINS; i++) begin
                if (sync2[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    filt[i]   <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 4'd1;
                end
            end
        end
    end
`else
    assign filt = sync2;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            prime_cnt <= '0;
            primed    <= 1'b0;
        end else if (!primed) begin
            if (prime_cnt == PRIME_LAST) primed <= 1'b1;
            else                         prime_cnt <= prime_cnt + 1'b1;
        end
    end

    // An edge in the same cycle as a W1C write wins: set is ORed after the clear.
    always_comb begin
        clr       = (bus_write && hit_pend) ? wr_val : '0;
        evt       = (~edge_sel & filt & ~prev) | (edge_sel & ~filt & prev);
        pend_next = (pend & ~clr) | (primed ? evt : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dir      <= '0;
            data_lat <= '0;
            ien      <= '0;
            edge_sel <= '0;
            pend     <= '0;
        end else begin
            if (bus_write && hit_dir)  dir      <= wr_val;
            if (bus_write && hit_data) data_lat <= wr_val;
            if (bus_write && hit_ien)  ien      <= wr_val;
            if (bus_write && hit_edge) edge_sel <= wr_val;
            pend <= pend_next;
        end
    end

    assign data_view = (dir & data_lat) | (~dir & filt);

    always_comb begin
        bus_data_out = '0;
        if (bus_read) begin
            if (hit_dir)  bus_data_out = 8'(dir);
            if (hit_data) bus_data_out = 8'(data_view);
            if (hit_ien)  bus_data_out = 8'(ien);
            if (hit_edge) bus_data_out = 8'(edge_sel);
            if (hit_pend) bus_data_out = 8'(pend);
        end
    end

endmodule

// File: tb/tb_gpio_port.sv
// Scoreboard bench for gpio_port: stimulus queues expected values, a negedge monitor checks them.
module tb_gpio_port;

`ifdef GPIO_DEBOUNCE_EN
    localparam int FD = 4;
`else
    localparam int FD = 0;
`endif
    localparam logic [23:0] BASE = 24'h2060;
    localparam int K_RD = 0, K_IRQ = 1, K_OUT = 2, K_OE = 3, K_BUS = 4;

    typedef struct {
        string      name;
        int         kind;
        logic [7:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, bus_write, bus_read, probe;
    logic [23:0] bus_address_in;
    logic [7:0]  bus_data_in, bus_data_out, pins_in, pins_out, pins_oe;
    logic        irq;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;

    gpio_port #(
        .NUM_PINS(8),
        .BASE_ADDR(BASE),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus_write(bus_write),
        .bus_read(bus_read),
        .bus_address_in(bus_address_in),
        .bus_data_in(bus_data_in),
        .bus_data_out(bus_data_out),
        .pins_in(pins_in),
        .pins_out(pins_out),
        .pins_oe(pins_oe),
        .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    exp_t       e;
    logic [7:0] act;
    always @(negedge clk) begin
        if (bus_read || probe) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: output presented with no expectation queued");
            end else begin
                e = sb.pop_front();
                case (e.kind)
                    K_IRQ:   act = {7'd0, irq};
                    K_OUT:   act = pins_out;
                    K_OE:    act = pins_oe;
                    default: act = bus_data_out;
                endcase
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input int off, input logic [7:0] d);
        bus_address_in = BASE + 24'(off);
        bus_data_in    = d;
        bus_write      = 1'b1;
        tick();
        bus_write      = 1'b0;
    endtask

    task automatic rd(input int off, input logic [7:0] ex, input string n);
        sb.push_back('{n, K_RD, ex});
        bus_address_in = BASE + 24'(off);
        bus_read       = 1'b1;
        tick();
        bus_read       = 1'b0;
    endtask

    task automatic chk(input int k, input logic [7:0] ex, input string n);
        sb.push_back('{n, k, ex});
        probe = 1'b1;
        tick();
        probe = 1'b0;
    endtask

    initial begin
        reset = 1'b1; bus_write = 1'b0; bus_read = 1'b0; probe = 1'b0;
        bus_address_in = '0; bus_data_in = '0; pins_in = 8'hFF;
        wait_n(3);
        chk(K_OUT, 8'h00, "rst_pins_out");
        chk(K_OE,  8'h00, "rst_pins_oe");
        chk(K_IRQ, 8'h00, "rst_irq");
        rd(4, 8'h00, "rst_pend");

        // Pins held high through reset must not create a rising-edge event.
        reset = 1'b0;
        wait_n(10);
        rd(4, 8'h00, "prime_pend");
        rd(1, 8'hFF, "prime_data");
        rd(0, 8'h00, "prime_dir");
        wr(2, 8'hFF);
        chk(K_IRQ, 8'h00, "prime_irq");
        wr(2, 8'h00);

        wr(0, 8'h0F);
        wr(1, 8'hA5);
        chk(K_OE,  8'h0F, "dir_pins_oe");
        chk(K_OUT, 8'hA5, "data_pins_out");
        pins_in = 8'h30;
        wait_n(FD + 3);
        rd(1, 8'h35, "data_mixed_read");
        rd(4, 8'h00, "no_rise_pend");

        // Rising edge on pin 0: irq exactly FD+2 posedges after the sampling edge.
        wr(2, 8'h01);
        pins_in = 8'h31;
        for (int i = 0; i < FD + 3; i++) chk(K_IRQ, 8'h00, "irq_before_rise");
        chk(K_IRQ, 8'h01, "irq_rise");
        rd(4, 8'h01, "pend_rise");
        wr(4, 8'h01);
        chk(K_IRQ, 8'h00, "irq_after_w1c");
        rd(4, 8'h00, "pend_after_w1c");

        wr(3, 8'h02);
        wr(2, 8'h00);
        pins_in = 8'h33;
        wait_n(FD + 4);
        pins_in = 8'h31;
        wait_n(FD + 4);
        rd(4, 8'h02, "pend_fall");
        chk(K_IRQ, 8'h00, "irq_masked");
        wr(2, 8'h02);
        chk(K_IRQ, 8'h01, "irq_unmasked");
        wr(4, 8'h02);
        wr(2, 8'h01);

        pins_in = 8'h30;
        wait_n(FD + 4);
        pins_in = 8'h31;
        wait_n(FD + 4);
        pins_in = 8'h30;
        wait_n(FD + 4);
        pins_in = 8'h31;
        wait_n(FD + 2);
        wr(4, 8'h01);
        rd(4, 8'h01, "pend_set_wins");
        wr(4, 8'h01);
        rd(4, 8'h00, "pend_w1c_plain");

        wr(3, 8'h03);
        wait_n(FD + 4);
        rd(4, 8'h00, "edge_no_retro");
        wr(3, 8'h00);

        wr(5, 8'hFF);
        rd(5, 8'h00, "undecoded_read");
        rd(-1, 8'h00, "below_base_read");
        rd(0, 8'h0F, "dir_intact");
        bus_address_in = BASE;
        chk(K_BUS, 8'h00, "no_read_zero");

        pins_in = 8'h30;
        wait_n(FD + 4);
        pins_in = 8'h31;
        wait_n(FD + 4);
        chk(K_IRQ, 8'h01, "irq_before_reset");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk(K_IRQ, 8'h00, "rst_mid_irq");
        chk(K_OE,  8'h00, "rst_mid_oe");
        chk(K_OUT, 8'h00, "rst_mid_out");
        rd(4, 8'h00, "rst_mid_pend");
        wait_n(10);
        rd(4, 8'h00, "rst_mid_prime");

`ifdef GPIO_DEBOUNCE_EN
        pins_in = 8'h35;
        wait_n(3);
        pins_in = 8'h31;
        rd(1, 8'h31, "db_glitch_data");
        wait_n(10);
        rd(4, 8'h00, "db_glitch_pend");
        pins_in = 8'h35;
        wait_n(6);
        pins_in = 8'h31;
        wait_n(12);
        rd(4, 8'h04, "db_pulse_pend");
`endif

        wait_n(5);
        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
